// File: rtl/rom_emulator_pkg.sv
// rom_emulator_pkg: shared state encoding and default sizes for the ROM emulator.
// Revision 1.0
`default_nettype none

package rom_emulator_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int CHECKSUM_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rom_emulator_array.sv
// rom_emulator_array: 1W/1R synchronous storage with registered, enable-held read data.
// Revision 1.0
`default_nettype none

module rom_emulator_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset: contents survive rst, and read data is only exposed once loaded.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_emulator.sv
// rom_emulator: loadable stand-in for the 8x1024 ROM macro (cs/addr/dout, 1-cycle reads).
// Optional ROM_EMULATOR_CHECKSUM_EN adds a running 16-bit sum of accepted load words. Revision 1.0
`default_nettype none

module rom_emulator
  import rom_emulator_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cs,
  input  logic [ADDR_WIDTH-1:0]     addr,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      rd_err,
  input  logic                      load_start,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [DATA_WIDTH-1:0]     load_data,
  output logic                      rom_ready
`ifdef ROM_EMULATOR_CHECKSUM_EN
  ,
  output logic [CHECKSUM_WIDTH-1:0] checksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic                  xfer;
  logic                  rd_ok;
  logic                  dout_zero;
  logic [DATA_WIDTH-1:0] rdata;

  // load_start wins over a same-cycle transfer; the last transfer wraps ptr to 0.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    xfer       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_next = ST_LOADING;
          ptr_next   = '0;
        end
      end
      ST_LOADING: begin
        if (load_start) begin
          ptr_next = '0;
        end else if (load_valid && load_ready) begin
          xfer     = 1'b1;
          ptr_next = ptr + 1'b1;
          if (ptr == LAST_ADDR) begin
            state_next = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (load_start) begin
          state_next = ST_LOADING;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  assign rd_ok = cs && (state == ST_READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      load_ready <= 1'b0;
      rom_ready  <= 1'b0;
      rd_err     <= 1'b0;
      dout_zero  <= 1'b1;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      load_ready <= (state_next == ST_LOADING);
      rom_ready  <= (state_next == ST_READY);
      rd_err     <= cs && (state != ST_READY);
      if (cs) begin
        dout_zero <= (state != ST_READY);
      end
    end
  end

  // Array read data is unreset, so a flag masks it to zero until a served read lands.
  assign dout = dout_zero ? '0 : rdata;

  rom_emulator_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (xfer),
    .waddr (ptr),
    .wdata (load_data),
    .re    (rd_ok),
    .raddr (addr),
    .rdata (rdata)
  );

`ifdef ROM_EMULATOR_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (load_start) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + CHECKSUM_WIDTH'(load_data);
    end
  end
`endif

endmodule

`default_nettype wire
